// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with PC, IR and retired-instruction counter.
// Define SEQ_TRAP_EN to enable illegal-opcode and misaligned-target traps; default build has no traps.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_rd_en1,
    input  logic        dec_rd_en2,
    input  logic [2:0]  dec_wr_en,
    input  logic [1:0]  dec_pc_jmp,
    input  logic [31:0] dec_imm,
    input  logic        alu_flag,
    output logic        rf_rd_en1,
    output logic        rf_rd_en2,
    output logic        rf_wr_en,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic [31:0] instret,
    output logic        trap
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        TRAP   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;

    logic        exec_taken;
    logic [31:0] exec_target;
    logic        opcode_ok;
    logic        target_misaligned;

    always_comb begin
        exec_taken = 1'b0;
        case (dec_pc_jmp)
            2'b00:   exec_taken = 1'b0;
            2'b01:   exec_taken = 1'b1;
            2'b10:   exec_taken = alu_flag;
            2'b11:   exec_taken = ~alu_flag;
            default: exec_taken = 1'b0;
        endcase
    end

    assign exec_target = pc_q + dec_imm;

`ifdef SEQ_TRAP_EN
    // Legal opcodes: R-type ALU, I-type ALU, branch, JAL, LUI.
    always_comb begin
        opcode_ok = 1'b0;
        case (ir_q[6:0])
            7'b0110011,
            7'b0010011,
            7'b1100011,
            7'b1101111,
            7'b0110111: opcode_ok = 1'b1;
            default:    opcode_ok = 1'b0;
        endcase
    end

    assign target_misaligned = exec_taken && (exec_target[1:0] != 2'b00);
    assign trap              = (state_q == TRAP);
`else
    assign opcode_ok         = 1'b1;
    assign target_misaligned = 1'b0;
    assign trap              = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        taken_d   = taken_q;
        target_d  = target_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = opcode_ok ? EXEC : TRAP;
            end
            EXEC: begin
                taken_d  = exec_taken;
                target_d = exec_target;
                state_d  = target_misaligned ? TRAP : WB;
            end
            WB: begin
                pc_d      = taken_q ? target_q : (pc_q + 32'd4);
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end
            TRAP: begin
                // Only reset leaves TRAP; pc and instret stay frozen here.
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            instret_q <= 32'd0;
            taken_q   <= 1'b0;
            target_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
        end
    end

    // Strobes are decoded from the state register so each lasts exactly one state.
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign instr     = ir_q;
    assign rf_rd_en1 = (state_q == DECODE) & dec_rd_en1;
    assign rf_rd_en2 = (state_q == DECODE) & dec_rd_en2;
    assign rf_wr_en  = (state_q == WB) & dec_wr_en[0];
    assign wb_sel    = dec_wr_en[2:1];
    assign pc        = pc_q;
    assign link_addr = pc_q + 32'd4;
    assign instret   = instret_q;

`ifndef SYNTHESIS
    a_wr_only_in_wb: assert property (@(posedge clk) disable iff (rst)
        rf_wr_en |-> (state_q == WB));

    a_fetch_wait_holds: assert property (@(posedge clk) disable iff (rst)
        (state_q == FETCH && !imem_ready) |=> (state_q == FETCH && $stable(pc_q)));

    a_ir_only_on_fetch: assert property (@(posedge clk) disable iff (rst)
        !(state_q == FETCH && imem_ready) |=> $stable(ir_q));
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: main process issues directed instructions and pushes
// expected retirements; a monitor pops and compares on every observed retirement.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        dec_rd_en1, dec_rd_en2;
    logic [2:0]  dec_wr_en;
    logic [1:0]  dec_pc_jmp;
    logic [31:0] dec_imm;
    logic        alu_flag;
    logic        rf_rd_en1, rf_rd_en2, rf_wr_en;
    logic [1:0]  wb_sel;
    logic [31:0] pc, link_addr, instret;
    logic        trap;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .dec_rd_en1 (dec_rd_en1),
        .dec_rd_en2 (dec_rd_en2),
        .dec_wr_en  (dec_wr_en),
        .dec_pc_jmp (dec_pc_jmp),
        .dec_imm    (dec_imm),
        .alu_flag   (alu_flag),
        .rf_rd_en1  (rf_rd_en1),
        .rf_rd_en2  (rf_rd_en2),
        .rf_wr_en   (rf_wr_en),
        .wb_sel     (wb_sel),
        .pc         (pc),
        .link_addr  (link_addr),
        .instret    (instret),
        .trap       (trap)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        wr;
        logic [31:0] link;
        logic [1:0]  wb_sel;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_instret = 32'd0;

    task automatic check32(input string tag, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, req);
        end
    endtask

    // Monitor: one line per retired instruction.
    initial begin : monitor
        logic [31:0] last_instret;
        int          wr_cnt;
        logic [31:0] wr_link;
        logic [1:0]  wr_sel;
        logic        rst_edge;
        exp_t        e;
        last_instret = 32'd0;
        wr_cnt       = 0;
        wr_link      = 32'd0;
        wr_sel       = 2'd0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #2;
            if (rst_edge) begin
                exp_q.delete();
                wr_cnt       = 0;
                last_instret = instret;
            end else begin
                if (rf_wr_en) begin
                    wr_cnt++;
                    wr_link = link_addr;
                    wr_sel  = wb_sel;
                end
                if (instret !== last_instret) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon.unexpected_retire: got instret %h expected no retirement", instret);
                    end else begin
                        e = exp_q.pop_front();
                        $display("retire: pc=%h instret=%0d wr_pulses=%0d", pc, instret, wr_cnt);
                        check32("mon", "retire_pc", pc, e.pc);
                        check32("mon", "retire_instret", instret, e.instret);
                        check32("mon", "wr_pulses", wr_cnt, {31'd0, e.wr});
                        if (e.wr) begin
                            check32("mon", "wb_link", wr_link, e.link);
                            check32("mon", "wb_sel", {30'd0, wr_sel}, {30'd0, e.wb_sel});
                        end
                    end
                    wr_cnt       = 0;
                    last_instret = instret;
                end
            end
        end
    end

    // Issue one instruction from FETCH; the bench plays both memory and decoder.
    task automatic do_instr(input string tag, input logic [31:0] word, input logic re1, input logic re2,
                            input logic [2:0] wr, input logic [1:0] jmp, input logic [31:0] imm,
                            input logic flag, input int waits, input logic [31:0] exp_pc);
        logic [31:0] start_pc;
        logic [31:0] old_ir;
        exp_t        e;
        dec_rd_en1 = re1;
        dec_rd_en2 = re2;
        dec_wr_en  = wr;
        dec_pc_jmp = jmp;
        dec_imm    = imm;
        alu_flag   = flag;
        imem_ready = 1'b0;
        start_pc   = pc;
        old_ir     = instr;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check32(tag, "wait_req", {31'd0, imem_req}, 32'd1);
            check32(tag, "wait_addr", imem_addr, start_pc);
            check32(tag, "wait_ir", instr, old_ir);
            check32(tag, "wait_rd_en", {31'd0, rf_rd_en1}, 32'd0);
        end
        e.pc       = exp_pc;
        e.instret  = model_instret + 32'd1;
        e.wr       = wr[0];
        e.link     = start_pc + 32'd4;
        e.wb_sel   = wr[2:1];
        exp_q.push_back(e);
        model_instret = model_instret + 32'd1;
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        check32(tag, "dec_ir", instr, word);
        check32(tag, "dec_rd_en1", {31'd0, rf_rd_en1}, {31'd0, re1});
        check32(tag, "dec_rd_en2", {31'd0, rf_rd_en2}, {31'd0, re2});
        check32(tag, "dec_req", {31'd0, imem_req}, 32'd0);
        imem_rdata = ~word;
        @(negedge clk);
        check32(tag, "exec_ir", instr, word);
        check32(tag, "exec_rd_en", {30'd0, rf_rd_en1, rf_rd_en2}, 32'd0);
        check32(tag, "exec_wr_en", {31'd0, rf_wr_en}, 32'd0);
        @(negedge clk);
        check32(tag, "wb_wr_en", {31'd0, rf_wr_en}, {31'd0, wr[0]});
        check32(tag, "wb_link", link_addr, start_pc + 32'd4);
        check32(tag, "wb_trap", {31'd0, trap}, 32'd0);
        imem_ready = 1'b0;
        @(negedge clk);
        check32(tag, "next_req", {31'd0, imem_req}, 32'd1);
        check32(tag, "next_addr", imem_addr, exp_pc);
        $display("instr %s: word=%h pc %h -> %h", tag, word, start_pc, pc);
    endtask

    initial begin : main
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        dec_rd_en1 = 1'b1;
        dec_rd_en2 = 1'b1;
        dec_wr_en  = 3'b001;
        dec_pc_jmp = 2'b00;
        dec_imm    = 32'd0;
        alu_flag   = 1'b0;
        repeat (2) @(negedge clk);
        check32("reset", "req", {31'd0, imem_req}, 32'd1);
        check32("reset", "addr", imem_addr, 32'h0);
        check32("reset", "ir", instr, 32'h0);
        check32("reset", "instret", instret, 32'h0);
        check32("reset", "strobes", {29'd0, rf_rd_en1, rf_rd_en2, rf_wr_en}, 32'd0);
        check32("reset", "trap", {31'd0, trap}, 32'd0);
        rst = 1'b0;
        model_instret = 32'd0;

        do_instr("addi",      32'h0050_0093, 1'b1, 1'b0, 3'b001, 2'b00, 32'd5,         1'b0, 0, 32'd4);
        do_instr("addi_wait", 32'h00A0_0113, 1'b1, 1'b0, 3'b001, 2'b00, 32'd10,        1'b0, 3, 32'd8);
        do_instr("beq_t",     32'h0000_0863, 1'b1, 1'b1, 3'b000, 2'b10, 32'd16,        1'b1, 0, 32'd24);
        do_instr("jmp_back",  32'h0000_006F, 1'b0, 1'b0, 3'b000, 2'b01, 32'hFFFF_FFF0, 1'b0, 0, 32'd8);
        do_instr("beq_nt",    32'h0000_0863, 1'b1, 1'b1, 3'b000, 2'b10, 32'd16,        1'b0, 1, 32'd12);
        do_instr("jmp_back2", 32'h0000_006F, 1'b0, 1'b0, 3'b000, 2'b01, 32'hFFFF_FFFC, 1'b1, 0, 32'd8);
        do_instr("bne_nt",    32'h0000_1863, 1'b1, 1'b1, 3'b000, 2'b11, 32'd16,        1'b1, 0, 32'd12);
        do_instr("jmp_fwd",   32'h0000_006F, 1'b0, 1'b0, 3'b000, 2'b01, 32'd20,        1'b0, 0, 32'd32);
        do_instr("jal",       32'hFF9F_F0EF, 1'b0, 1'b0, 3'b101, 2'b01, 32'hFFFF_FFF8, 1'b0, 0, 32'd24);
        do_instr("jmp_top",   32'h0000_006F, 1'b0, 1'b0, 3'b000, 2'b01, 32'hFFFF_FFE4, 1'b0, 0, 32'hFFFF_FFFC);
        do_instr("pc_wrap",   32'h0010_0093, 1'b1, 1'b0, 3'b001, 2'b00, 32'd1,         1'b0, 0, 32'd0);
        do_instr("addi2",     32'h0010_0093, 1'b1, 1'b0, 3'b001, 2'b00, 32'd1,         1'b0, 0, 32'd4);

        // Reset in the middle of a FETCH wait.
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("rst_fetch", "pc", pc, 32'h0);
        check32("rst_fetch", "instret", instret, 32'h0);
        check32("rst_fetch", "wr_en", {31'd0, rf_wr_en}, 32'd0);
        rst = 1'b0;
        model_instret = 32'd0;
        $display("reset during fetch wait: pc=%h instret=%0d", pc, instret);

        // Reset while the write strobe is active in WB.
        do_instr("addi3", 32'h0050_0093, 1'b1, 1'b0, 3'b001, 2'b00, 32'd5, 1'b0, 0, 32'd4);
        dec_wr_en  = 3'b001;
        dec_pc_jmp = 2'b00;
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        repeat (3) @(negedge clk);
        check32("rst_wb", "wb_wr_en", {31'd0, rf_wr_en}, 32'd1);
        rst        = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        check32("rst_wb", "pc", pc, 32'h0);
        check32("rst_wb", "instret", instret, 32'h0);
        check32("rst_wb", "wr_en", {31'd0, rf_wr_en}, 32'd0);
        check32("rst_wb", "req", {31'd0, imem_req}, 32'd1);
        rst = 1'b0;
        model_instret = 32'd0;
        $display("reset during wb: pc=%h instret=%0d", pc, instret);

        // Load opcode: traps when checks are enabled, otherwise completes normally.
        do_instr("addi4", 32'h0050_0093, 1'b1, 1'b0, 3'b001, 2'b00, 32'd5, 1'b0, 0, 32'd4);
`ifdef SEQ_TRAP_EN
        dec_wr_en  = 3'b001;
        dec_pc_jmp = 2'b00;
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_2083;
        @(negedge clk);
        check32("trap", "dec_trap", {31'd0, trap}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check32("trap", "trap", {31'd0, trap}, 32'd1);
            check32("trap", "req", {31'd0, imem_req}, 32'd0);
            check32("trap", "wr_en", {31'd0, rf_wr_en}, 32'd0);
            check32("trap", "pc", pc, 32'd4);
            check32("trap", "instret", instret, 32'd1);
            @(negedge clk);
        end
        rst        = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        check32("trap", "after_rst", {31'd0, trap}, 32'd0);
        check32("trap", "after_rst_pc", pc, 32'h0);
        rst = 1'b0;
        model_instret = 32'd0;
        $display("trap on load opcode cleared by reset: pc=%h", pc);
`else
        do_instr("load_notrap", 32'h0000_2083, 1'b1, 1'b0, 3'b001, 2'b00, 32'd0, 1'b0, 0, 32'd8);
        check32("load_notrap", "trap", {31'd0, trap}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check32("end", "pending_expectations", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
